// File: rtl/ff_write_arbiter.sv
// ff_write_arbiter: round-robin arbiter for four requesters writing one shared register.
// A grant lasts one cycle; its closing edge commits the write and pulses done.
module ff_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_req,
  input  logic [4*WIDTH-1:0] i_data,
  input  logic               i_clr,
  output logic [3:0]         o_gnt,
  output logic [WIDTH-1:0]   o_q,
  output logic [WIDTH-1:0]   o_qb,
  output logic               o_done,
  output logic [1:0]         o_done_id,
  output logic               o_busy,
  output logic [7:0]         o_wr_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_ptr, r_idx, w_win;
  logic w_any;
  // Scan from lowest priority (ptr) to highest (ptr+1) so the last hit wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (i_req[r_ptr + 2'(k)]) begin
        w_win = r_ptr + 2'(k);
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (i_clr) w_next = IDLE;
    else if (r_state == IDLE) w_next = w_any ? GRANT : IDLE;
    else w_next = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt     <= '0;
      o_q       <= '0;
      o_done    <= 1'b0;
      o_done_id <= '0;
      o_wr_cnt  <= '0;
      r_ptr     <= 2'd3;
      r_idx     <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_clr) begin
        o_q   <= '0;
        o_gnt <= '0;
      end else if (r_state == IDLE) begin
        if (w_any) begin
          o_gnt <= 4'b0001 << w_win;
          r_idx <= w_win;
        end
      end else begin
        o_q       <= i_data[r_idx*WIDTH +: WIDTH];
        r_ptr     <= r_idx;
        o_gnt     <= '0;
        o_done    <= 1'b1;
        o_done_id <= r_idx;
        o_wr_cnt  <= o_wr_cnt + 8'd1;
      end
    end
  end
  assign o_qb   = ~o_q;
  assign o_busy = (r_state == GRANT);
endmodule

// File: doc/ff_write_arbiter.md
FF_WRITE_ARBITER -- requirements
Module: ff_write_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of the shared register.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-004 req  input  4  per-requester write request, bit i = requester i; level-sensitive.
REQ-005 data  input  4*WIDTH  requester i write data on bits [i*WIDTH +: WIDTH].
REQ-006 clr  input  1  synchronous clear of the shared register; highest priority.
REQ-007 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-008 q  output  WIDTH  shared register contents.
REQ-009 qb  output  WIDTH  bitwise complement of q.
REQ-010 done  output  1  one-cycle pulse after each completed write.
REQ-011 done_id  output  2  index of the requester whose write completed; valid when done=1.
REQ-012 busy  output  1  high while FSM is not IDLE.
REQ-013 wr_cnt  output  8  count of completed writes.

Function
REQ-014 FSM SHALL have exactly two states, IDLE and GRANT.
REQ-015 IDLE, req!=0, clr=0: SHALL pick the winner by round-robin, register gnt=onehot(winner), go to GRANT.
REQ-016 Round-robin order SHALL search ptr+1, ptr+2, ptr+3, ptr (mod 4); first requester with req=1 wins.
REQ-017 IDLE, req=0: SHALL stay in IDLE with gnt=0.
REQ-018 GRANT: at the closing edge, q SHALL load data slice of the granted requester, sampled at that edge.
REQ-019 Same edge: ptr SHALL take the winner index, gnt SHALL return to 0, done SHALL go to 1 for one cycle, done_id SHALL be the winner index, wr_cnt SHALL increment, FSM SHALL return to IDLE.
REQ-020 GRANT SHALL last exactly one cycle; a req drop during GRANT SHALL NOT cancel the write.
REQ-021 Latency: req high before edge E1 -> gnt high after E1 -> q updated and done high after E2; max throughput one write per two cycles.
REQ-022 A requester holding req high SHALL NOT win again while another requester has req high (fairness).
REQ-023 clr=1 at an edge, any state: q SHALL become 0, gnt SHALL become 0, FSM SHALL go to IDLE, no write, no done, no wr_cnt change, ptr unchanged.
REQ-024 qb SHALL equal ~q in every cycle, including the cycle of a q update and during reset; qb is never one edge behind q.
REQ-025 wr_cnt SHALL wrap 255 -> 0 without side effects.
REQ-026 busy SHALL be 1 exactly when the FSM is in GRANT.
REQ-027 done SHALL be 0 in any cycle not directly following a completed GRANT.

Reset
REQ-028 rst low SHALL force: FSM=IDLE, gnt=0, q=0, qb=all ones, done=0, done_id=0, wr_cnt=0, ptr=3, so requester 0 has first priority.
REQ-029 rst low during GRANT SHALL abort the write: q=0, no done pulse.
REQ-030 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst high.

Verification
REQ-031 Reset then req=4'b1111 held: gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; done_id 0,1,2,3.
REQ-032 req=4'b0100, data[2]=8'hA5: gnt=0100 one cycle, then q=8'hA5, qb=8'h5A, done=1, done_id=2, wr_cnt=1.
REQ-033 clr=1 in the GRANT cycle (q=8'h3C beforehand): q=8'h00, qb=8'hFF, done stays 0, wr_cnt unchanged.
REQ-034 rst pulsed low mid-GRANT, asynchronous to clk: all outputs at reset values immediately; requester 0 granted first afterwards.
REQ-035 256 consecutive writes from requester 1: wr_cnt returns to 0; done pulses 256 times.
REQ-036 Every cycle, all scenarios: qb==~q, gnt one-hot or zero, busy==(gnt!=0).
